light_conflict_monitor: RTL
===========================

LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 2, minimum cycles a yellow lamp must be lit before red.
REQ-002 Parameter FLASH_DIV, default 4, cycles per half-period of the fault flash output.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Ports RA, YA, GA  input  1 each  lamp drives of lane A, from the traffic light controller.
REQ-006 Ports RB, YB, GB  input  1 each  lamp drives of lane B.
REQ-007 Port clr_fault  input  1  operator request to clear a latched fault.
REQ-008 Port fault  output  1  latched fault indication.
REQ-009 Port fault_code  output  3  cause of the latched fault; 0 when fault=0.
REQ-010 Port flash  output  1  forced-flash enable to lamp drivers; equals fault.
REQ-011 Port flash_on  output  1  blink phase; toggles every FLASH_DIV cycles while flash=1, else 0.
REQ-012 Port phase_cnt  output  8  count of legal lane-A lamp changes, saturating at 255.

Function
REQ-013 The monitor SHALL register all six lamp inputs each cycle and evaluate each check on the current inputs against the previous registered sample.
REQ-014 The monitor SHALL have states ARMING, MONITOR, FAULT.
REQ-015 ARMING SHALL capture lamp state for one cycle and perform only static checks (REQ-017..018), then go to MONITOR.
REQ-016 Legal per-lane sequence SHALL be R->G->Y->R; an unchanged lamp is always legal.
REQ-017 Code 1 CONFLICT: both lanes simultaneously not red (RA=0 and RB=0).
REQ-018 Code 2 LAMP_A / code 3 LAMP_B: the lane does not have exactly one of R, Y, G lit.
REQ-019 Code 4 SEQ_A / code 5 SEQ_B: a lamp change other than the legal sequence (e.g. G->R, Y->G, R->Y).
REQ-020 Code 6 SHORT_Y_A / code 7 SHORT_Y_B: Y->R taken after fewer than MIN_YELLOW consecutive yellow samples.
REQ-021 Sequence and yellow checks SHALL not be evaluated against a sample that failed a lamp check.
REQ-022 Any violation in ARMING or MONITOR SHALL move to FAULT, with fault=1 and fault_code set in the cycle after the offending sample.
REQ-023 Simultaneous violations SHALL record the lowest code.
REQ-024 FAULT SHALL hold fault_code unchanged and ignore further violations.
REQ-025 clr_fault=1 in FAULT SHALL return to ARMING and clear fault, fault_code, flash_on, and the flash counter next cycle; clr_fault is ignored outside FAULT.
REQ-026 The yellow counter SHALL saturate at MIN_YELLOW and reset on any non-yellow sample of its lane.
REQ-027 phase_cnt SHALL increment once per legal lane-A change in MONITOR, hold at 255, and hold in FAULT.
REQ-028 flash_on SHALL be 1 in the first FAULT cycle, then invert every FLASH_DIV cycles.

Reset
REQ-029 rst=0 SHALL asynchronously force ARMING, fault=0, fault_code=0, flash=0, flash_on=0, phase_cnt=0, cleared lamp history, and cleared yellow and flash counters.
REQ-030 Reset asserted mid-FAULT SHALL discard the latched fault; no fault persists across reset.

Structure
REQ-031 The state enumeration and fault-code constants (0..7) SHALL live in a shared traffic package used by the controller and this monitor.
REQ-032 A per-lane checker sub-module lane_seq_checker (lamp legality, sequence, yellow count) SHALL be instantiated once for A and once for B.

Verification
REQ-033 Legal cycle A: G,Y,Y,R with B red throughout, then repeated -> fault stays 0 and phase_cnt increments by 3 per full cycle.
REQ-034 GA=1 and GB=1 with both reds 0 -> fault=1, fault_code=1 the next cycle, flash_on pattern 1111 0000 repeated.
REQ-035 Lane A goes G->R directly -> fault_code=4; a B lamp of 000 in the same sample -> fault_code=3 (lamp check precedes sequence check).
REQ-036 Lane B yellow for 1 cycle then red with MIN_YELLOW=2 -> fault_code=7; clr_fault pulse -> fault=0 next cycle, then ARMING.
REQ-037 phase_cnt preloaded by 300 legal changes -> reads 255 and holds.
REQ-038 rst pulled low mid-FAULT, asynchronously to clk -> all outputs 0 immediately; after release, the first sample is checked statically only.

Source files
------------

// File: rtl/light_conflict_monitor_pkg.sv
// rtl/light_conflict_monitor_pkg.sv - shared traffic states, fault codes and lamp encodings
package light_conflict_monitor_pkg;

    typedef enum logic [1:0] {
        ST_ARMING  = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_t;

    localparam logic [2:0] CODE_NONE      = 3'd0;
    localparam logic [2:0] CODE_CONFLICT  = 3'd1;
    localparam logic [2:0] CODE_LAMP_A    = 3'd2;
    localparam logic [2:0] CODE_LAMP_B    = 3'd3;
    localparam logic [2:0] CODE_SEQ_A     = 3'd4;
    localparam logic [2:0] CODE_SEQ_B     = 3'd5;
    localparam logic [2:0] CODE_SHORT_Y_A = 3'd6;
    localparam logic [2:0] CODE_SHORT_Y_B = 3'd7;

    // Lamp vectors are packed {R, Y, G}.
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    function automatic logic [2:0] legal_next(input logic [2:0] lamp);
        logic [2:0] nxt;
        case (lamp)
            LAMP_R:  nxt = LAMP_G;
            LAMP_G:  nxt = LAMP_Y;
            LAMP_Y:  nxt = LAMP_R;
            default: nxt = 3'b000;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/light_conflict_monitor_if.sv
// rtl/light_conflict_monitor_if.sv - lamp inputs and fault outputs of the conflict monitor
interface light_conflict_monitor_if;
    logic       RA, YA, GA;
    logic       RB, YB, GB;
    logic       clr_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash;
    logic       flash_on;
    logic [7:0] phase_cnt;

    modport master (
        output RA, YA, GA, RB, YB, GB, clr_fault,
        input  fault, fault_code, flash, flash_on, phase_cnt
    );

    modport slave (
        input  RA, YA, GA, RB, YB, GB, clr_fault,
        output fault, fault_code, flash, flash_on, phase_cnt
    );
endinterface

// File: rtl/light_conflict_monitor_lane_seq_checker.sv
// rtl/light_conflict_monitor_lane_seq_checker.sv - per-lane lamp legality, sequence and yellow-time checks
module lane_seq_checker
    import light_conflict_monitor_pkg::*;
#(
    parameter int MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_lamp,
    input  logic [2:0] i_prev,
    input  logic       i_dyn_en,
    output logic       o_lamp_err,
    output logic       o_seq_err,
    output logic       o_short_y
);
    localparam int YW = $clog2(MIN_YELLOW + 1);

    logic [YW-1:0] r_ycnt;
    logic          w_cur_ok;
    logic          w_dyn;

    // Transition checks only apply when both samples are well-formed lamp states.
    assign w_cur_ok   = $onehot(i_lamp);
    assign w_dyn      = i_dyn_en && w_cur_ok && $onehot(i_prev);
    assign o_lamp_err = !w_cur_ok;
    assign o_seq_err  = w_dyn && (i_lamp != i_prev) && (i_lamp != legal_next(i_prev));
    assign o_short_y  = w_dyn && (i_prev == LAMP_Y) && (i_lamp == LAMP_R)
                        && (r_ycnt < YW'(MIN_YELLOW));

    // Counts consecutive pure-yellow samples; anything else restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ycnt <= '0;
        end else if (i_lamp == LAMP_Y) begin
            if (r_ycnt != YW'(MIN_YELLOW)) begin
                r_ycnt <= r_ycnt + 1'b1;
            end
        end else begin
            r_ycnt <= '0;
        end
    end
endmodule

// File: rtl/light_conflict_monitor.sv
// rtl/light_conflict_monitor.sv - two-lane traffic lamp conflict monitor with latched fault and flash
module light_conflict_monitor
    import light_conflict_monitor_pkg::*;
#(
    parameter int MIN_YELLOW = 2,
    parameter int FLASH_DIV  = 4
) (
    input logic                     clk,
    input logic                     rst,
    light_conflict_monitor_if.slave bus
);
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    mon_state_t    r_state;
    logic          r_fault;
    logic [2:0]    r_code;
    logic          r_flash_on;
    logic [FW-1:0] r_fcnt;
    logic [7:0]    r_phase;
    logic [2:0]    r_prev_a;
    logic [2:0]    r_prev_b;

    logic [2:0] w_lamp_a;
    logic [2:0] w_lamp_b;
    logic       w_dyn_en;
    logic       w_a_lamp_err, w_a_seq_err, w_a_short_y;
    logic       w_b_lamp_err, w_b_seq_err, w_b_short_y;
    logic [7:1] w_viol;
    logic [2:0] w_code;

    assign w_lamp_a = {bus.RA, bus.YA, bus.GA};
    assign w_lamp_b = {bus.RB, bus.YB, bus.GB};
    assign w_dyn_en = (r_state == ST_MONITOR);

    lane_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_lane_a (
        .clk(clk), .rst(rst), .i_lamp(w_lamp_a), .i_prev(r_prev_a), .i_dyn_en(w_dyn_en),
        .o_lamp_err(w_a_lamp_err), .o_seq_err(w_a_seq_err), .o_short_y(w_a_short_y)
    );

    lane_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_lane_b (
        .clk(clk), .rst(rst), .i_lamp(w_lamp_b), .i_prev(r_prev_b), .i_dyn_en(w_dyn_en),
        .o_lamp_err(w_b_lamp_err), .o_seq_err(w_b_seq_err), .o_short_y(w_b_short_y)
    );

    always_comb begin
        w_viol                 = '0;
        w_viol[CODE_CONFLICT]  = !bus.RA && !bus.RB;
        w_viol[CODE_LAMP_A]    = w_a_lamp_err;
        w_viol[CODE_LAMP_B]    = w_b_lamp_err;
        w_viol[CODE_SEQ_A]     = w_a_seq_err;
        w_viol[CODE_SEQ_B]     = w_b_seq_err;
        w_viol[CODE_SHORT_Y_A] = w_a_short_y;
        w_viol[CODE_SHORT_Y_B] = w_b_short_y;
        // Lowest code wins when several checks trip together.
        w_code = CODE_NONE;
        for (int i = 7; i >= 1; i--) begin
            if (w_viol[i]) begin
                w_code = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_ARMING;
            r_fault    <= 1'b0;
            r_code     <= CODE_NONE;
            r_flash_on <= 1'b0;
            r_fcnt     <= '0;
            r_phase    <= 8'd0;
            r_prev_a   <= 3'b000;
            r_prev_b   <= 3'b000;
        end else begin
            r_prev_a <= w_lamp_a;
            r_prev_b <= w_lamp_b;
            case (r_state)
                ST_FAULT: begin
                    if (bus.clr_fault) begin
                        r_state    <= ST_ARMING;
                        r_fault    <= 1'b0;
                        r_code     <= CODE_NONE;
                        r_flash_on <= 1'b0;
                        r_fcnt     <= '0;
                    end else if (r_fcnt == FW'(FLASH_DIV - 1)) begin
                        r_fcnt     <= '0;
                        r_flash_on <= ~r_flash_on;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                default: begin
                    if (w_code != CODE_NONE) begin
                        r_state    <= ST_FAULT;
                        r_fault    <= 1'b1;
                        r_code     <= w_code;
                        r_flash_on <= 1'b1;
                        r_fcnt     <= '0;
                    end else begin
                        r_state <= ST_MONITOR;
                        // Only a clean sample in MONITOR counts as an accepted lane-A change.
                        if (w_dyn_en && (w_lamp_a != r_prev_a) && (r_phase != 8'hFF)) begin
                            r_phase <= r_phase + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.fault      = r_fault;
    assign bus.fault_code = r_code;
    assign bus.flash      = r_fault;
    assign bus.flash_on   = r_flash_on;
    assign bus.phase_cnt  = r_phase;
endmodule
